axi_wchan_router: RTL

- Companion to the write-address arbiter: it handles the return and data side of the 2-master AXI write path.
- Records which master won each accepted AW handshake in an order FIFO.
- Steers W beats from the owning master to the slave, until WLAST.
- Routes each B response back to the master that issued the matching AW, in issue order.
- Sits in the interconnect between the two master ports and the single slave port.

---
 rtl/axi_ic_pkg.sv | 16 +
 rtl/axi_order_fifo.sv | 50 +++++
 rtl/axi_wchan_router.sv | 131 +++++++++++++
 3 files changed

// File: rtl/axi_ic_pkg.sv
// Shared types for the 2-master AXI write interconnect.
package axi_ic_pkg;

  typedef logic master_idx_t;

  localparam master_idx_t MST0 = 1'b0;
  localparam master_idx_t MST1 = 1'b1;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi_order_fifo.sv
// Master-index order FIFO: one write port, independent W-side and B-side read heads.
module axi_order_fifo
  import axi_ic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  master_idx_t push_idx,
  input  logic        w_pop,
  input  logic        b_pop,
  output master_idx_t w_head,
  output master_idx_t b_head,
  output logic [CW-1:0] w_cnt,
  output logic [CW-1:0] b_cnt
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    b_ptr;

  // Contents need no reset: counters gate every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      w_ptr  <= '0;
      b_ptr  <= '0;
      w_cnt  <= '0;
      b_cnt  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (w_pop) w_ptr  <= w_ptr + PW'(1);
      if (b_pop) b_ptr  <= b_ptr + PW'(1);
      w_cnt <= w_cnt + CW'(push) - CW'(w_pop);
      b_cnt <= b_cnt + CW'(push) - CW'(b_pop);
    end
  end

  assign w_head = mem[w_ptr];
  assign b_head = mem[b_ptr];

endmodule

// File: rtl/axi_wchan_router.sv
// Steers W beats and B responses between two masters and one slave in AW issue order.
module axi_wchan_router
  import axi_ic_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m1_wgrnt,
  input  logic              awvalid,
  input  logic              awready,
  output logic              aw_block_o,
  input  logic              m0_WVALID,
  input  logic              m0_WLAST,
  input  logic [DATA_W-1:0] m0_WDATA,
  input  logic [STRB_W-1:0] m0_WSTRB,
  output logic              m0_WREADY,
  input  logic              m1_WVALID,
  input  logic              m1_WLAST,
  input  logic [DATA_W-1:0] m1_WDATA,
  input  logic [STRB_W-1:0] m1_WSTRB,
  output logic              m1_WREADY,
  output logic              s_WVALID,
  output logic              s_WLAST,
  output logic [DATA_W-1:0] s_WDATA,
  output logic [STRB_W-1:0] s_WSTRB,
  input  logic              s_WREADY,
  input  logic              s_BVALID,
  input  logic [1:0]        s_BRESP,
  output logic              s_BREADY,
  output logic              m0_BVALID,
  output logic [1:0]        m0_BRESP,
  input  logic              m0_BREADY,
  output logic              m1_BVALID,
  output logic [1:0]        m1_BRESP,
  input  logic              m1_BREADY,
  output logic              err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  master_idx_t   w_head;
  master_idx_t   b_head;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] b_cnt;
  logic          w_act;
  logic          b_act;
  logic          push;
  logic          w_pop;
  logic          b_pop;

  assign w_act      = (w_cnt != '0);
  assign b_act      = (b_cnt != '0);
  assign aw_block_o = (b_cnt == CW'(DEPTH));
  assign push       = awvalid && awready && !aw_block_o;
  assign w_pop      = s_WVALID && s_WREADY && s_WLAST;
  assign b_pop      = s_BVALID && s_BREADY;

  axi_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push),
    .push_idx (m1_wgrnt),
    .w_pop    (w_pop),
    .b_pop    (b_pop),
    .w_head   (w_head),
    .b_head   (b_head),
    .w_cnt    (w_cnt),
    .b_cnt    (b_cnt)
  );

  // Data outputs are forced to zero whenever their valid is low.
  always_comb begin
    s_WVALID  = 1'b0;
    s_WLAST   = 1'b0;
    s_WDATA   = '0;
    s_WSTRB   = '0;
    m0_WREADY = 1'b0;
    m1_WREADY = 1'b0;
    if (w_act) begin
      if (w_head == MST1) begin
        s_WVALID  = m1_WVALID;
        m1_WREADY = s_WREADY;
        if (m1_WVALID) begin
          s_WLAST = m1_WLAST;
          s_WDATA = m1_WDATA;
          s_WSTRB = m1_WSTRB;
        end
      end else begin
        s_WVALID  = m0_WVALID;
        m0_WREADY = s_WREADY;
        if (m0_WVALID) begin
          s_WLAST = m0_WLAST;
          s_WDATA = m0_WDATA;
          s_WSTRB = m0_WSTRB;
        end
      end
    end
  end

  always_comb begin
    s_BREADY  = 1'b0;
    m0_BVALID = 1'b0;
    m0_BRESP  = '0;
    m1_BVALID = 1'b0;
    m1_BRESP  = '0;
    if (b_act) begin
      if (b_head == MST1) begin
        m1_BVALID = s_BVALID;
        m1_BRESP  = s_BVALID ? s_BRESP : '0;
        s_BREADY  = m1_BREADY;
      end else begin
        m0_BVALID = s_BVALID;
        m0_BRESP  = s_BVALID ? s_BRESP : '0;
        s_BREADY  = m0_BREADY;
      end
    end
  end

  // A response with no outstanding write, or before its WLAST, is a slave protocol violation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (s_BVALID && (!b_act || (b_cnt == w_cnt))) begin
      err_o <= 1'b1;
    end
  end

endmodule
